// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, parity modes, idle line level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input, resetting to the idle line level.
// Latency: 2 clk. No backpressure.
module uart_sync_2ff
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= LINE_IDLE;
      q    <= LINE_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fsmd.sv
// UART receiver FSMD on an oversampled clock; optional 2-of-3 bit vote under UART_RX_MAJORITY_EN.
// Latency: data_valid 2 + N/2 + N*(DATA_SIZE+PARITY_ON+1) + 1 clk after the start edge.
// No backpressure: data_valid is a one-cycle pulse, the consumer must take it.
module uart_rx_fsmd
  import uart_pkg::*;
#(
  parameter int DATA_SIZE           = 8,
  parameter int PARITY_ON           = 1,
  parameter int PARITY_ODD          = 0,
  parameter int NO_OF_CLKS          = 16,
  parameter int SAMPLING_CNTR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_en,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int                TW       = SAMPLING_CNTR_WIDTH;
  localparam logic [TW-1:0]     HALF_END = TW'(NO_OF_CLKS / 2 - 1);
  localparam logic [TW-1:0]     BIT_END  = TW'(NO_OF_CLKS - 1);
  localparam logic [2:0]        LAST_BIT = 3'(DATA_SIZE - 1);
  localparam logic              PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  localparam bit                HAS_PAR  = (PARITY_ON != 0);

  rx_state_t              state;
  logic [TW-1:0]          tick;
  logic [2:0]             bit_cnt;
  logic [DATA_SIZE-1:0]   shreg;
  logic                   par_bit;
  logic                   pend;
  logic                   rx_s;
  logic [TW-1:0]          end_val;
  logic                   samp_tick;
  logic                   decide;
  logic                   bit_val;
`ifdef UART_RX_MAJORITY_EN
  logic                   v1;
  logic                   v2;
`else
  logic                   stop_smp;
`endif

  uart_sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // pend marks the extra cycle after the nominal tick: the vote cycle, or the
  // cycle that publishes a frame after its stop sample.
  always_comb begin
    end_val   = (state == START) ? HALF_END : BIT_END;
    samp_tick = (tick == end_val);
`ifdef UART_RX_MAJORITY_EN
    decide    = pend;
    bit_val   = maj3(v1, v2, rx_s);
`else
    decide    = (state == STOP) ? pend : samp_tick;
    bit_val   = (state == STOP) ? stop_smp : rx_s;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      pend       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      v1         <= LINE_IDLE;
      v2         <= LINE_IDLE;
`else
      stop_smp   <= LINE_IDLE;
`endif
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          pend    <= 1'b0;
          if (rx_en && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        BRK_WAIT: begin
          if (rx_s == LINE_IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
`ifdef UART_RX_MAJORITY_EN
          // Vote cycle sits at tick 0 of the next bit, so restarting at 1 keeps the bit period.
          if (pend) begin
            pend <= 1'b0;
            tick <= TW'(1);
          end else if (samp_tick) begin
            v2   <= rx_s;
            pend <= 1'b1;
            tick <= '0;
          end else begin
            if (tick == end_val - TW'(1))
              v1 <= rx_s;
            tick <= tick + TW'(1);
          end
`else
          if (pend) begin
            pend <= 1'b0;
          end else if (samp_tick) begin
            tick <= '0;
            if (state == STOP) begin
              stop_smp <= rx_s;
              pend     <= 1'b1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
`endif
          if (decide) begin
            case (state)
              START: begin
                if (bit_val) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= DATA;
                end
              end

              DATA: begin
                shreg <= (shreg >> 1) | (DATA_SIZE'(bit_val) << (DATA_SIZE - 1));
                if (bit_cnt == LAST_BIT)
                  state <= HAS_PAR ? PARITY : STOP;
                else
                  bit_cnt <= bit_cnt + 3'd1;
              end

              PARITY: begin
                par_bit <= bit_val;
                state   <= STOP;
              end

              STOP: begin
                data_out   <= shreg;
                parity_err <= HAS_PAR && (par_bit != ((^shreg) ^ PAR_MODE));
                frame_err  <= ~bit_val;
                data_valid <= 1'b1;
                if (bit_val) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= BRK_WAIT;
                end
              end

              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Self-checking bench for uart_rx_fsmd: frame table plus break, glitch, enable, spike and reset sequences.
module tb_uart_rx_fsmd;

  localparam int LAT = 2 + 16 / 2 + 16 * (8 + 1 + 1) + 1;  // 171

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_fsmd #(
    .DATA_SIZE(8), .PARITY_ON(1), .PARITY_ODD(0), .NO_OF_CLKS(16), .SAMPLING_CNTR_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_en(rx_en),
    .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] SPK_D  = 8'hFF;
  localparam logic       SPK_PE = 1'b0;
`else
  localparam logic [7:0] SPK_D  = 8'hFB;
  localparam logic       SPK_PE = 1'b1;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic dv_q = 1'b0;
  vec_t tbl[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      chk("valid_one_cycle", {31'd0, dv_q}, 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got data_out=%0h at cycle %0d, expected no valid", data_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("data_out", {24'd0, data_out}, {24'd0, mon_e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
        chk("valid_cycle", cyc, mon_e.due);
      end
    end
    dv_q <= data_valid;
  end

  // Called #1 after a clk edge; returns #1 after the edge ending the stop bit.
  task automatic send(input logic [7:0] d, input logic par, input logic stop, input int spike_c,
                      input bit push, input logic [7:0] ed, input logic epe, input logic efe);
    exp_t e;
    logic v;
    int   b;
    if (push) begin
      e.d = ed; e.pe = epe; e.fe = efe; e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
    for (int c = 0; c < 176; c++) begin
      b = c / 16;
      if (b == 0)      v = 1'b0;
      else if (b <= 8) v = d[b-1];
      else if (b == 9) v = par;
      else             v = stop;
      if (c == spike_c) v = 1'b0;
      rx_in = v;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    tbl[6] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    tbl[7] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_parity_err", {31'd0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst   = 1'b1;
    rx_en = 1'b1;
    idle(5);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].d, tbl[i].par, tbl[i].stop, -1, 1'b1, tbl[i].ed, tbl[i].epe, tbl[i].efe);
      idle(20);
    end
    chk("busy_after_table", {31'd0, busy}, 32'd0);

    // Break: stop bit low, line held low 40 more clk.
    send(8'h55, 1'b0, 1'b0, -1, 1'b1, 8'h55, 1'b0, 1'b1);
    rx_in = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("brk_busy_held", {31'd0, busy}, 32'd1);
    repeat (20) begin @(posedge clk); #1; end
    chk("brk_busy_still", {31'd0, busy}, 32'd1);
    idle(6);
    chk("brk_busy_released", {31'd0, busy}, 32'd0);
    idle(20);

    // Glitch: three clk low.
    rx_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rx_in = 1'b1;
    chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
    waited = 0;
    while (busy === 1'b1 && waited < 11) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
    idle(20);

    // Back-to-back frames 176 clk apart.
    send(8'h00, 1'b0, 1'b1, -1, 1'b1, 8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1, -1, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle(20);

    // Single-clk low spike seen by the receiver only at the bit-2 sample tick.
    send(8'hFF, 1'b0, 1'b1, 56, 1'b1, SPK_D, SPK_PE, 1'b0);
    idle(20);

    // rx_en dropped mid-frame: frame completes, then the line is ignored.
    fork
      send(8'hC3, 1'b0, 1'b1, -1, 1'b1, 8'hC3, 1'b0, 1'b0);
      begin repeat (60) @(posedge clk); #1 rx_en = 1'b0; end
    join
    idle(10);
    send(8'h0F, 1'b0, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("disabled_busy", {31'd0, busy}, 32'd0);
    idle(10);
    rx_en = 1'b1;
    idle(5);

    // Async reset mid-frame discards the partial frame.
    fork
      send(8'hFF, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0);
      begin
        repeat (80) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_data_out", {24'd0, data_out}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
      end
    join
    idle(30);
    chk("final_busy", {31'd0, busy}, 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
